pad_echo_responder: RTL and testbench

Responder end of the padded-word test interface: consumes 16-bit words that a tester produces by zero-extending an 11-bit payload, strips and checks the pad, tags each payload with a sequence number, and returns it on a buffered output stream. It sits in place of the external `SimpleExtModule`-style DUT in tester harnesses. This lets `foo` stimulus be checked and echoed back as `bar` with backpressure and ordering guarantees.

---
 rtl/pad_echo_pkg.sv | 12 +
 rtl/pad_echo_fifo.sv | 59 +++++
 rtl/pad_echo_responder.sv | 93 +++++++++
 tb/tb_pad_echo_responder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pad_echo_pkg.sv
// Shared widths and response layout for the padded-word echo responder.
package pad_echo_pkg;
  localparam int PAYLOAD_W = 11;
  localparam int WORD_W    = 16;
  localparam int TAG_W     = 5;
  localparam int ERRCNT_W  = 8;

  typedef struct packed {
    logic [TAG_W-1:0]     tag;
    logic [PAYLOAD_W-1:0] payload;
  } resp_t;
endpackage

// File: rtl/pad_echo_fifo.sv
// Synchronous FIFO, registered storage; head visible one cycle after push.
// wr side refused while full (no same-cycle pass-through); rd held while !rd_rdy_i.
module pad_echo_fifo
  import pad_echo_pkg::*;
#(
  parameter int W     = WORD_W,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         wr_vld_i,
  input  logic [W-1:0] wr_dat_i,
  output logic         full_o,
  output logic         rd_vld_o,
  input  logic         rd_rdy_i,
  output logic [W-1:0] rd_dat_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o   = (cnt_q == DEPTH_C);
  assign rd_vld_o = (cnt_q != '0);
  assign do_push  = wr_vld_i && !full_o;
  assign do_pop   = rd_vld_o && rd_rdy_i;
  assign rd_dat_o = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (do_push) mem_q[wr_ptr_q] <= wr_dat_i;
    end
  end
endmodule

// File: rtl/pad_echo_responder.sv
// Strips/checks the pad on foo, tags payloads and echoes them in order on bar; 1-cycle latency.
// foo_ready = !full (no path from bar_ready); PAD_ERR_CHECK_EN enables pad drop and error counters.
module pad_echo_responder
  import pad_echo_pkg::*;
#(
  parameter int IN_WIDTH = PAYLOAD_W,
  parameter int N        = WORD_W,
  parameter int DEPTH    = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                foo_valid,
  output logic                foo_ready,
  input  logic [N-1:0]        foo,
  output logic                bar_valid,
  input  logic                bar_ready,
  output logic [N-1:0]        bar,
  output logic                pad_err,
  output logic [ERRCNT_W-1:0] err_count,
  input  logic                err_clear
);
  localparam int TW = N - IN_WIDTH;

  logic          fifo_full;
  logic          accept;
  logic          pad_bad;
  logic          push;
  logic [TW-1:0] tag_q, tag_d;

  assign foo_ready = !fifo_full;
  assign accept    = foo_valid && foo_ready;

`ifdef PAD_ERR_CHECK_EN
  logic                pad_err_q, pad_err_d;
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

  assign pad_bad = |foo[N-1:IN_WIDTH];

  // Clear wins over a simultaneous violation.
  always_comb begin
    pad_err_d = pad_err_q;
    err_cnt_d = err_cnt_q;
    if (err_clear) begin
      pad_err_d = 1'b0;
      err_cnt_d = '0;
    end else if (accept && pad_bad) begin
      pad_err_d = 1'b1;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pad_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      pad_err_q <= pad_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign pad_err   = pad_err_q;
  assign err_count = err_cnt_q;
`else
  logic unused_pad;
  assign unused_pad = ^{err_clear, foo[N-1:IN_WIDTH]};
  assign pad_bad    = 1'b0;
  assign pad_err    = 1'b0;
  assign err_count  = '0;
`endif

  assign push  = accept && !pad_bad;
  assign tag_d = push ? tag_q + 1'b1 : tag_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) tag_q <= '0;
    else       tag_q <= tag_d;
  end

  pad_echo_fifo #(
    .W     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .wr_vld_i (push),
    .wr_dat_i ({tag_q, foo[IN_WIDTH-1:0]}),
    .full_o   (fifo_full),
    .rd_vld_o (bar_valid),
    .rd_rdy_i (bar_ready),
    .rd_dat_o (bar)
  );
endmodule

// File: tb/tb_pad_echo_responder.sv
// Randomised and directed bench for pad_echo_responder against a queue-based reference model.
module tb_pad_echo_responder;
  import pad_echo_pkg::*;

  localparam int DEPTH = 4;
`ifdef PAD_ERR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        foo_valid = 1'b0;
  logic        foo_ready;
  logic [15:0] foo = '0;
  logic        bar_valid;
  logic        bar_ready = 1'b0;
  logic [15:0] bar;
  logic        pad_err;
  logic [7:0]  err_count;
  logic        err_clear = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  resp_t       mq[$];
  int          mtag = 0;
  bit          merr = 1'b0;
  int          mcnt = 0;
  logic [15:0] dut_pops[$];

  pad_echo_responder #(.IN_WIDTH(11), .N(16), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .foo_valid (foo_valid),
    .foo_ready (foo_ready),
    .foo       (foo),
    .bar_valid (bar_valid),
    .bar_ready (bar_ready),
    .bar       (bar),
    .pad_err   (pad_err),
    .err_count (err_count),
    .err_clear (err_clear)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] popv(input int i);
    return (i < dut_pops.size()) ? dut_pops[i] : 16'hxxxx;
  endfunction

  // Model: outputs for the current cycle, then the state after the coming edge.
  always @(negedge clock) begin
    int occ;
    bit acc, bad;
    resp_t r;
    if (reset) begin
      mq.delete();
      mtag = 0;
      merr = 1'b0;
      mcnt = 0;
    end
    chk("foo_ready", 32'(foo_ready), 32'(mq.size() < DEPTH));
    chk("bar_valid", 32'(bar_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("bar", 32'(bar), 32'(mq[0]));
    chk("pad_err", 32'(pad_err), 32'(merr));
    chk("err_count", 32'(err_count), 32'(mcnt));
    if (!reset) begin
      if (bar_valid && bar_ready) dut_pops.push_back(bar);
      occ = mq.size();
      acc = foo_valid && (occ < DEPTH);
      bad = CHK && (foo[15:11] != 5'd0);
      if (bar_ready && occ > 0) void'(mq.pop_front());
      if (acc && !bad) begin
        r.tag     = 5'(mtag);
        r.payload = foo[10:0];
        mq.push_back(r);
        mtag = (mtag + 1) % 32;
      end
      if (CHK && err_clear) begin
        merr = 1'b0;
        mcnt = 0;
      end else if (acc && bad) begin
        merr = 1'b1;
        if (mcnt < 255) mcnt++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    foo_valid = 1'b0;
    err_clear = 1'b0;
    cyc(2);
    reset = 1'b0;
    dut_pops.delete();
  endtask

  task automatic send(input logic [15:0] w);
    bit ok;
    ok = 1'b0;
    foo_valid = 1'b1;
    foo = w;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clock);
      ok = foo_ready;
      @(posedge clock);
      #1;
    end
    foo_valid = 1'b0;
    chk("send_accepted", 32'(ok), 32'd1);
  endtask

  logic [10:0] pl33 [33];

  initial begin
    cyc(2);
    chk("rst_foo_ready", 32'(foo_ready), 32'd1);
    chk("rst_bar_valid", 32'(bar_valid), 32'd0);
    chk("rst_bar", 32'(bar), 32'd0);
    chk("rst_pad_err", 32'(pad_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    reset = 1'b0;

    // Basic echo and first-cycle latency
    bar_ready = 1'b1;
    send(16'h04D2);
    @(negedge clock);
    chk("lat_bar_valid", 32'(bar_valid), 32'd1);
    chk("lat_bar", 32'(bar), 32'h04D2);
    @(posedge clock); #1;
    send(16'h04D2);
    cyc(3);
    chk("echo_npops", dut_pops.size(), 2);
    chk("echo_0", 32'(popv(0)), 32'h04D2);
    chk("echo_1", 32'(popv(1)), 32'h0CD2);

    // Fill under backpressure, then drain in order
    do_reset();
    bar_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(16'(i));
    @(negedge clock);
    chk("full_foo_ready", 32'(foo_ready), 32'd0);
    @(posedge clock); #1;
    bar_ready = 1'b1;
    cyc(6);
    chk("fill_npops", dut_pops.size(), 4);
    chk("fill_0", 32'(popv(0)), 32'h0001);
    chk("fill_1", 32'(popv(1)), 32'h0802);
    chk("fill_2", 32'(popv(2)), 32'h1003);
    chk("fill_3", 32'(popv(3)), 32'h1804);

    // Pad violation
    do_reset();
    send(16'h84D2);
    send(16'h0005);
    cyc(3);
`ifdef PAD_ERR_CHECK_EN
    chk("pad_err_set", 32'(pad_err), 32'd1);
    chk("pad_cnt_1", 32'(err_count), 32'd1);
    chk("pad_npops", dut_pops.size(), 1);
    chk("pad_resp", 32'(popv(0)), 32'h0005);
    err_clear = 1'b1;
    cyc(1);
    err_clear = 1'b0;
    chk("clr_pad_err", 32'(pad_err), 32'd0);
    chk("clr_err_count", 32'(err_count), 32'd0);
    err_clear = 1'b1;
    send(16'hF800);
    err_clear = 1'b0;
    chk("clrprio_pad_err", 32'(pad_err), 32'd0);
    chk("clrprio_err_count", 32'(err_count), 32'd0);
`else
    chk("nopad_npops", dut_pops.size(), 2);
    chk("nopad_0", 32'(popv(0)), 32'h04D2);
    chk("nopad_1", 32'(popv(1)), 32'h0805);
    chk("nopad_pad_err", 32'(pad_err), 32'd0);
`endif

    // 300 violating words
    do_reset();
    for (int i = 0; i < 300; i++) send({5'($urandom_range(1, 31)), 11'($urandom)});
    cyc(3);
`ifdef PAD_ERR_CHECK_EN
    chk("sat_err_count", 32'(err_count), 32'd255);
    chk("sat_npops", dut_pops.size(), 0);
`else
    chk("sat_npops", dut_pops.size(), 300);
    chk("sat_err_count", 32'(err_count), 32'd0);
`endif

    // Tag wrap over 33 words
    do_reset();
    for (int i = 0; i < 33; i++) begin
      pl33[i] = 11'($urandom);
      send({5'd0, pl33[i]});
    end
    cyc(3);
    chk("wrap_npops", dut_pops.size(), 33);
    chk("wrap_tag31", 32'(popv(31) >> 11), 32'd31);
    chk("wrap_tag32", 32'(popv(32) >> 11), 32'd0);
    chk("wrap_pl32", 32'(popv(32) & 16'h07FF), 32'(pl33[32]));

    // Reset with entries queued
    do_reset();
    bar_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(16'h0100 + 16'(i));
    reset = 1'b1;
    #1;
    chk("mrst_bar_valid", 32'(bar_valid), 32'd0);
    chk("mrst_foo_ready", 32'(foo_ready), 32'd1);
    @(posedge clock); #1;
    reset = 1'b0;
    dut_pops.delete();
    bar_ready = 1'b1;
    send(16'h0123);
    cyc(2);
    chk("mrst_resp", 32'(popv(0)), 32'h0123);

    // Random traffic, checked every cycle by the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      foo_valid = ($urandom_range(0, 3) != 0);
      foo = ($urandom_range(0, 3) == 0) ? 16'($urandom) : {5'd0, 11'($urandom)};
      bar_ready = ((i / 500) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      err_clear = ($urandom_range(0, 31) == 0);
      reset = (i == 1500);
      cyc(1);
    end
    reset = 1'b0;
    foo_valid = 1'b0;
    err_clear = 1'b0;
    bar_ready = 1'b1;
    cyc(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
